axis_ifft_frame_packer: RTL and testbench
=========================================

# axis_ifft_frame_packer

Upstream feeder for the 8-point IFFT stage. It accepts a serial AXI4-Stream of complex frequency-domain bins, one bin per beat (32-bit real, 32-bit imag). It gathers each group of 8 bins into one 512-bit frame in the IFFT input layout, and presents that frame on a master AXI4-Stream port. Short frames, marked by an early `tlast`, are zero-padded or dropped depending on build configuration. A small saturating counter reports how many short frames have occurred.

## Interface
Parameters:
- `C_AXIS_TDATA_WIDTH`, 64 — input beat width; must be 64.
- `C_AXIS_TOUT_WIDTH`, 512 — output frame width; must be 8 × `C_AXIS_TDATA_WIDTH`.
- `C_SHORT_CNT_WIDTH`, 16 — width of the short-frame counter.

Ports:
- `s_axis_aclk`  in  1 — single clock for both sides.
- `s_axis_areset`  in  1 — reset, asynchronous assert, active-high.
- `s_axis_tvalid`  in  1 — input beat valid.
- `s_axis_tready`  out  1 — input beat accepted when high together with `tvalid`.
- `s_axis_tdata`  in  64 — one bin: [63:32] real, [31:0] imag, both signed two's complement.
- `s_axis_tlast`  in  1 — last bin of a frame.
- `m_axis_tvalid`  out  1 — frame valid.
- `m_axis_tready`  in  1 — downstream accepts frame.
- `m_axis_tdata`  out  512 — frame. Bin k occupies [64k+63:64k], with real in the upper 32 bits and imag in the lower 32 bits.
- `m_axis_tlast`  out  1 — frame was closed by input `tlast`.
- `m_axis_tuser`  out  1 — frame was zero-padded (short frame).
- `short_frame_cnt`  out  `C_SHORT_CNT_WIDTH` — saturating count of short frames.

## Operation
- **Collector.** A 3-bit index `cnt` counts 0..7. An accepted beat (`s_axis_tvalid & s_axis_tready`) writes bin `cnt` and increments `cnt`.
- **Frame completion.** A frame completes on either of these events, after which `cnt` returns to 0:
  - the beat at `cnt == 7` is accepted (regardless of `tlast`), or
  - a beat with `tlast = 1` is accepted at `cnt < 7`.
- **Full frame.** `cnt == 7` with `tlast = 1` gives `m_axis_tlast = 1`, `m_axis_tuser = 0`. `cnt == 7` with `tlast = 0` gives `m_axis_tlast = 0`, `m_axis_tuser = 0`; this is a continuous stream.
- **Short frame.** Input `tlast` at `cnt = k < 7` is a short frame. It increments `short_frame_cnt`, which saturates at all-ones and does not wrap. Handling is set by the configuration macro.
- **State machine.** Two states:
  - FILL: collecting bins.
  - PEND: a frame has completed, but the output register was occupied and not draining on that edge.
- **Transitions.**
  - FILL → output register: on frame completion, if `~m_axis_tvalid | m_axis_tready`, the frame, including the completing beat, loads the output register on the same edge.
  - FILL → PEND: on frame completion otherwise.
  - PEND → FILL: when `~m_axis_tvalid | m_axis_tready`, the held frame loads the output register.
- `s_axis_tready = ~PEND & ~s_axis_areset`.
- The output register holds `tdata`, `tlast` and `tuser` stable while `m_axis_tvalid & ~m_axis_tready`. `m_axis_tvalid` clears after a handshake unless a new frame loads on the same edge.
- No arithmetic is performed; bins pass through bit-exact.
- **Reset.** Reset mid-frame discards partial bins and any pending or held frame. Reset values:
  - `cnt` = 0, state = FILL.
  - `m_axis_tvalid` = 0, `m_axis_tdata` = 0, `m_axis_tlast` = 0, `m_axis_tuser` = 0.
  - `short_frame_cnt` = 0.

## Timing
- **Latency.** The completing beat is accepted at edge t; `m_axis_tvalid` is high from t+1.
- **Throughput.** 1 bin/cycle sustained; one frame per 8 cycles when `m_axis_tready` is continuously high.
- **Backpressure.** A completed frame that meets a full output register enters PEND. `s_axis_tready` drops the cycle after the completing beat and rises the cycle after the output drains.
- **Simultaneous events.** An output handshake and a frame load on the same edge produce back-to-back valid frames with no bubble.
- **Output registers.** All outputs are registered except `s_axis_tready`, which is combinational from state and reset.

## Configuration
- **`IFFT_PACK_SHORT_PAD_EN` defined.** A short frame at `cnt = k`:
  - bins k+1..7 are zero;
  - the frame is emitted with `m_axis_tlast = 1`, `m_axis_tuser = 1`.
- **Not defined.** A short frame is discarded:
  - `cnt` returns to 0 and no output frame is produced;
  - `m_axis_tuser` is tied to 0;
  - `short_frame_cnt` still increments.

## Test plan
- **Reset.** Assert reset for 3 cycles → all outputs 0 and `s_axis_tready = 0`; after release, `s_axis_tready = 1`.
- **Full frame.** Stream bins k = 0..7 with real = k+1, imag = −(k+1), `tlast` on bin 7, `m_axis_tready = 1` →
  - one frame on the cycle after bin 7;
  - `tdata[63:32] = 1`, `tdata[31:0] = 0xFFFFFFFF`, `tdata[511:480] = 8`;
  - `tlast = 1`, `tuser = 0`.
- **Backpressure.** Hold `m_axis_tready = 0` and stream 16 bins →
  - frame 1 held stable;
  - after bin 15, PEND is entered and `s_axis_tready = 0`;
  - raising `m_axis_tready` drains both frames in order with no data loss.
- **Short frame, PAD_EN defined.** `tlast` on bin 2 →
  - frame with bins 3..7 = 0, `tlast = 1`, `tuser = 1`;
  - `short_frame_cnt = 1`.
- **Short frame, PAD_EN undefined.** `tlast` on bin 2, then 8 normal bins →
  - exactly one output frame, containing the 8 normal bins;
  - `short_frame_cnt = 1`.
- **Reset mid-frame and saturation.** Reset after 5 bins, then 8 bins → a single frame containing only the post-reset bins. Separately, with `C_SHORT_CNT_WIDTH = 2`, send 5 short frames → counter reads 3.

Source files
------------

// File: rtl/axis_ifft_frame_packer.sv
// Packs eight serial 64-bit complex bins into one 512-bit IFFT input frame.
// Define IFFT_PACK_SHORT_PAD_EN to zero-pad and emit short frames; otherwise short frames are dropped.
module axis_ifft_frame_packer #(
  parameter int C_AXIS_TDATA_WIDTH = 64,
  parameter int C_AXIS_TOUT_WIDTH  = 512,
  parameter int C_SHORT_CNT_WIDTH  = 16
) (
  input  logic                          s_axis_aclk,
  input  logic                          s_axis_areset,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                          s_axis_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [C_AXIS_TOUT_WIDTH-1:0]  m_axis_tdata,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tuser,
  output logic [C_SHORT_CNT_WIDTH-1:0]  short_frame_cnt
);

  typedef enum logic {FILL, PEND} state_t;

  state_t                         state;
  logic [2:0]                     cnt;
  logic [C_AXIS_TOUT_WIDTH-1:0]   acc;
  logic [C_AXIS_TOUT_WIDTH-1:0]   frame_next;
  logic                           pend_last;
  logic                           accept;
  logic                           complete;
  logic                           short_frame;
  logic                           emit;
  logic                           out_ready;

  // acc is cleared after every frame, so bins above a short-frame tlast are already zero
  always_comb begin
    frame_next = acc;
    frame_next[int'(cnt) * C_AXIS_TDATA_WIDTH +: C_AXIS_TDATA_WIDTH] = s_axis_tdata;
  end

  assign s_axis_tready = (state != PEND) & ~s_axis_areset;
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign complete      = accept & ((cnt == 3'd7) | s_axis_tlast);
  assign short_frame   = s_axis_tlast & (cnt != 3'd7);
  assign out_ready     = ~m_axis_tvalid | m_axis_tready;

`ifdef IFFT_PACK_SHORT_PAD_EN
  logic pend_user;
  assign emit = 1'b1;
`else
  assign emit         = ~short_frame;
  assign m_axis_tuser = 1'b0;
`endif

  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      state           <= FILL;
      cnt             <= 3'd0;
      acc             <= '0;
      pend_last       <= 1'b0;
      m_axis_tvalid   <= 1'b0;
      m_axis_tdata    <= '0;
      m_axis_tlast    <= 1'b0;
      short_frame_cnt <= '0;
`ifdef IFFT_PACK_SHORT_PAD_EN
      pend_user       <= 1'b0;
      m_axis_tuser    <= 1'b0;
`endif
    end else begin
      // A load below overrides this clear, giving back-to-back frames
      if (m_axis_tvalid & m_axis_tready)
        m_axis_tvalid <= 1'b0;

      case (state)
        FILL: begin
          if (accept) begin
            if (!complete) begin
              acc <= frame_next;
              cnt <= cnt + 3'd1;
            end else begin
              cnt <= 3'd0;
              if (short_frame && (short_frame_cnt != {C_SHORT_CNT_WIDTH{1'b1}}))
                short_frame_cnt <= short_frame_cnt + {{(C_SHORT_CNT_WIDTH-1){1'b0}}, 1'b1};
              if (emit && out_ready) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= frame_next;
                m_axis_tlast  <= s_axis_tlast;
`ifdef IFFT_PACK_SHORT_PAD_EN
                m_axis_tuser  <= short_frame;
`endif
                acc           <= '0;
              end else if (emit) begin
                acc       <= frame_next;
                pend_last <= s_axis_tlast;
`ifdef IFFT_PACK_SHORT_PAD_EN
                pend_user <= short_frame;
`endif
                state     <= PEND;
              end else begin
                acc <= '0;
              end
            end
          end
        end

        PEND: begin
          if (out_ready) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= acc;
            m_axis_tlast  <= pend_last;
`ifdef IFFT_PACK_SHORT_PAD_EN
            m_axis_tuser  <= pend_user;
`endif
            acc           <= '0;
            state         <= FILL;
          end
        end

        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_ifft_frame_packer.sv
// Scoreboard testbench for axis_ifft_frame_packer; honours IFFT_PACK_SHORT_PAD_EN when defined.
module tb_axis_ifft_frame_packer;

  localparam int BUDGET = 200;

  typedef struct {
    logic [511:0] data;
    logic         last;
    logic         user;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         s_tvalid = 1'b0;
  logic         s_tready;
  logic [63:0]  s_tdata = '0;
  logic         s_tlast = 1'b0;
  logic         m_tvalid;
  logic         m_tready = 1'b0;
  logic [511:0] m_tdata;
  logic         m_tlast;
  logic         m_tuser;
  logic [15:0]  short_cnt;

  logic         sat_tvalid = 1'b0;
  logic         sat_tready;
  logic         sat_tlast = 1'b0;
  logic         sat_m_tvalid;
  logic [511:0] sat_m_tdata;
  logic         sat_m_tlast;
  logic         sat_m_tuser;
  logic [1:0]   sat_cnt;

  exp_t         exp_q[$];
  logic [511:0] model_frame = '0;
  int           model_cnt = 0;
  logic [511:0] last_pushed = '0;
  int           checks = 0;
  int           fails = 0;
  int           frames_seen = 0;

  always #5 clk = ~clk;

  axis_ifft_frame_packer dut (
    .s_axis_aclk(clk), .s_axis_areset(rst),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tdata(m_tdata), .m_axis_tlast(m_tlast),
    .m_axis_tuser(m_tuser), .short_frame_cnt(short_cnt)
  );

  axis_ifft_frame_packer #(.C_SHORT_CNT_WIDTH(2)) dut_sat (
    .s_axis_aclk(clk), .s_axis_areset(rst),
    .s_axis_tvalid(sat_tvalid), .s_axis_tready(sat_tready),
    .s_axis_tdata(64'h0000_0007_FFFF_FFF9), .s_axis_tlast(sat_tlast),
    .m_axis_tvalid(sat_m_tvalid), .m_axis_tready(1'b1),
    .m_axis_tdata(sat_m_tdata), .m_axis_tlast(sat_m_tlast),
    .m_axis_tuser(sat_m_tuser), .short_frame_cnt(sat_cnt)
  );

  task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one beat, wait for acceptance, and update the reference frame model
  task automatic applyStimulus(input logic [63:0] data, input logic last);
    int waited = 0;
    bit done = 0;
    bit short_f;
    s_tvalid = 1'b1;
    s_tdata  = data;
    s_tlast  = last;
    while (!done && waited < BUDGET) begin
      @(negedge clk);
      if (s_tready) begin
        @(posedge clk);
        #1;
        done = 1;
      end else begin
        waited++;
      end
    end
    if (!done) begin
      checks++;
      fails++;
      $error("[TB] FAIL tready_timeout observed=%0d expected=<%0d", waited, BUDGET);
    end
    model_frame[model_cnt*64 +: 64] = data;
    if (model_cnt == 7 || last) begin
      short_f = (model_cnt != 7);
      if (!short_f) begin
        exp_q.push_back('{model_frame, last, 1'b0});
        last_pushed = model_frame;
      end
`ifdef IFFT_PACK_SHORT_PAD_EN
      else begin
        exp_q.push_back('{model_frame, 1'b1, 1'b1});
        last_pushed = model_frame;
      end
`endif
      model_frame = '0;
      model_cnt   = 0;
    end else begin
      model_cnt++;
    end
  endtask

  task automatic idle(input int n);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Outputs are stable at the falling edge; a handshake seen here completes on the next rising edge
  always @(negedge clk) begin
    if (!rst && m_tvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $error("[TB] FAIL unexpected_frame observed=%0h expected=none", m_tdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("frame_data", m_tdata, e.data);
        checkOutput("frame_last", m_tlast, e.last);
        checkOutput("frame_user", m_tuser, e.user);
        frames_seen++;
      end
    end
  end

  initial begin
    logic [31:0]  re;
    logic [31:0]  im;
    logic [511:0] frame1;
    int           seen0;

    // Reset held for three cycles
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_m_tvalid", m_tvalid, 1'b0);
    checkOutput("rst_m_tdata", m_tdata, '0);
    checkOutput("rst_m_tlast", m_tlast, 1'b0);
    checkOutput("rst_m_tuser", m_tuser, 1'b0);
    checkOutput("rst_s_tready", s_tready, 1'b0);
    checkOutput("rst_short_cnt", short_cnt, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_s_tready", s_tready, 1'b1);
    @(posedge clk);
    #1;

    // Full frame with real=k+1, imag=-(k+1)
    m_tready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      re = 32'(k + 1);
      im = -re;
      applyStimulus({re, im}, k == 7);
    end
    s_tvalid = 1'b0;
    checkOutput("lat_valid", m_tvalid, 1'b1);
    checkOutput("full_bin0_re", m_tdata[63:32], 32'd1);
    checkOutput("full_bin0_im", m_tdata[31:0], 32'hFFFF_FFFF);
    checkOutput("full_bin7_re", m_tdata[511:480], 32'd8);
    checkOutput("full_tlast", m_tlast, 1'b1);
    checkOutput("full_tuser", m_tuser, 1'b0);
    idle(3);
    checkOutput("full_drained", m_tvalid, 1'b0);

    // Backpressure: 16 bins into a blocked output
    m_tready = 1'b0;
    frame1 = '0;
    for (int k = 0; k < 16; k++) begin
      applyStimulus({$urandom, $urandom}, (k % 8) == 7);
      if (k == 7) frame1 = last_pushed;
    end
    s_tvalid = 1'b0;
    @(negedge clk);
    checkOutput("bp_s_tready_low", s_tready, 1'b0);
    checkOutput("bp_frame1_held", m_tdata, frame1);
    checkOutput("bp_valid_held", m_tvalid, 1'b1);
    @(posedge clk);
    #1;
    m_tready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    checkOutput("bp_s_tready_rise", s_tready, 1'b1);
    checkOutput("bp_frame2_valid", m_tvalid, 1'b1);
    idle(3);
    checkOutput("bp_queue_empty", 32'(exp_q.size()), 32'd0);

    // Short frame: tlast on bin 2, then a normal frame
    seen0 = frames_seen;
    for (int k = 0; k < 3; k++)
      applyStimulus({32'hA000_0000 + 32'(k), 32'h0B00_0000 + 32'(k)}, k == 2);
    for (int k = 0; k < 8; k++)
      applyStimulus({32'hC000_0000 + 32'(k), 32'h0D00_0000 + 32'(k)}, k == 7);
    idle(4);
    checkOutput("short_cnt_one", short_cnt, 16'd1);
`ifdef IFFT_PACK_SHORT_PAD_EN
    checkOutput("short_frames_seen", 32'(frames_seen - seen0), 32'd2);
`else
    checkOutput("short_frames_seen", 32'(frames_seen - seen0), 32'd1);
`endif

    // Reset mid-frame after 5 bins
    for (int k = 0; k < 5; k++)
      applyStimulus({32'hDEAD_0000 + 32'(k), 32'hBEEF_0000 + 32'(k)}, 1'b0);
    s_tvalid = 1'b0;
    rst = 1'b1;
    model_frame = '0;
    model_cnt = 0;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("midrst_short_cnt", short_cnt, '0);
    seen0 = frames_seen;
    for (int k = 0; k < 8; k++)
      applyStimulus({32'h1234_0000 + 32'(k), 32'h5678_0000 + 32'(k)}, k == 7);
    idle(4);
    checkOutput("midrst_frames_seen", 32'(frames_seen - seen0), 32'd1);
    checkOutput("midrst_queue_empty", 32'(exp_q.size()), 32'd0);

    // Counter saturation on the 2-bit instance
    sat_tvalid = 1'b1;
    sat_tlast  = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    checkOutput("sat_cnt_three", sat_cnt, 2'd3);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    sat_tvalid = 1'b0;
    sat_tlast  = 1'b0;
    idle(2);
    checkOutput("sat_cnt_hold", sat_cnt, 2'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
